// File: rtl/mpsk_modulator_if.sv
// Symbol handshake between the framing logic and the M-PSK modulator.
// The framer drives valid/data; the modulator answers with ready.
interface mpsk_modulator_if #(
    parameter int BITS_PER_SYMBOL = 1
) ();
    logic                       sym_valid;
    logic [BITS_PER_SYMBOL-1:0] sym_data;
    logic                       sym_ready;

    modport master (
        output sym_valid,
        output sym_data,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_data,
        output sym_ready
    );
endinterface

// File: rtl/mpsk_modulator.sv
// M-ary PSK carrier modulator: one registered DAC sample per clock,
// each symbol an integral number of phase-shifted carrier cycles.
module wave_table_sine #(
    parameter int DATA_WIDTH = 8,
    parameter int WAVELENGTH = 16,
    localparam int PW        = $clog2(WAVELENGTH)
) (
    input  logic [PW-1:0]         i_phase,
    output logic [DATA_WIDTH-1:0] o_sample
);
    // Integer Bhaskara sine, rounded; exact to the LSB for 8-bit codes.
    function automatic int sine_code(input int idx);
        int h, mid, amp, j, q, num, den, mag;
        h   = WAVELENGTH / 2;
        mid = 1 << (DATA_WIDTH - 1);
        amp = mid - 1;
        j   = (idx < h) ? idx : idx - h;
        q   = j * (h - j);
        num = 16 * q * amp;
        den = 5 * h * h - 4 * q;
        mag = (2 * num + den) / (2 * den);
        return (idx < h) ? mid + mag : mid - mag;
    endfunction

    logic [DATA_WIDTH-1:0] w_tab [WAVELENGTH];

    for (genvar g = 0; g < WAVELENGTH; g++) begin : g_tab
        assign w_tab[g] = DATA_WIDTH'(sine_code(g));
    end

    assign o_sample = w_tab[i_phase];
endmodule

module mpsk_modulator #(
    parameter int DATA_WIDTH        = 8,
    parameter int WAVELENGTH        = 16,
    parameter int BITS_PER_SYMBOL   = 1,
    parameter int CYCLES_PER_SYMBOL = 1,
    parameter int GRAY              = 0,
    parameter int DIFF              = 0,
    parameter int IDLE_LEVEL        = 2 ** (DATA_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    mpsk_modulator_if.slave       s_sym,
    output logic [DATA_WIDTH-1:0] signal_out,
    output logic                  active,
    output logic                  sym_last,
    output logic                  underrun
);
    localparam int M    = 1 << BITS_PER_SYMBOL;
    localparam int SPS  = WAVELENGTH * CYCLES_PER_SYMBOL;
    localparam int CW   = $clog2(SPS);
    localparam int PW   = $clog2(WAVELENGTH);
    localparam int STEP = WAVELENGTH / M;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [PW-1:0]              r_phase;
    logic [BITS_PER_SYMBOL-1:0] r_acc;

    logic                       w_at_end;
    logic                       w_ready;
    logic                       w_hs;
    logic [BITS_PER_SYMBOL-1:0] w_sym;
    logic [BITS_PER_SYMBOL-1:0] w_bin;
    logic [BITS_PER_SYMBOL-1:0] w_acc_new;
    logic [BITS_PER_SYMBOL-1:0] w_p;
    logic [PW-1:0]              w_offset;
    logic [PW-1:0]              w_phase;
    logic [PW-1:0]              w_phase_nxt;
    logic [DATA_WIDTH-1:0]      w_sample;

    function automatic logic [BITS_PER_SYMBOL-1:0] gray2bin(
        input logic [BITS_PER_SYMBOL-1:0] g
    );
        logic [BITS_PER_SYMBOL-1:0] b;
        for (int i = 0; i < BITS_PER_SYMBOL; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign w_at_end = (r_cnt == CW'(SPS - 1));
    assign w_ready  = enable && ((r_state == S_IDLE) || w_at_end);
    assign w_hs     = s_sym.sym_valid && w_ready;
    assign w_sym    = s_sym.sym_data;
    assign s_sym.sym_ready = w_ready;

    assign w_bin     = (GRAY != 0) ? gray2bin(w_sym) : w_sym;
    assign w_acc_new = r_acc + w_bin;
    assign w_p       = (DIFF != 0) ? w_acc_new : w_bin;
    assign w_offset  = PW'(32'(w_p) * STEP);

    // At a handshake the table reads the new offset directly, so sample 0
    // lands on the output one cycle later with no gap between symbols.
    assign w_phase     = w_hs ? w_offset : r_phase;
    assign w_phase_nxt = (w_phase == PW'(WAVELENGTH - 1)) ?
                         '0 : w_phase + 1'b1;

    wave_table_sine #(
        .DATA_WIDTH (DATA_WIDTH),
        .WAVELENGTH (WAVELENGTH)
    ) u_tab (
        .i_phase  (w_phase),
        .o_sample (w_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_acc      <= '0;
            signal_out <= DATA_WIDTH'(IDLE_LEVEL);
            active     <= 1'b0;
            sym_last   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            sym_last <= 1'b0;
            if (w_hs) begin
                r_state    <= S_RUN;
                r_cnt      <= '0;
                r_phase    <= w_phase_nxt;
                signal_out <= w_sample;
                active     <= 1'b1;
                sym_last   <= (SPS == 1);
                if (DIFF != 0) begin
                    r_acc <= w_acc_new;
                end
            end else if (r_state == S_RUN && !w_at_end) begin
                r_cnt      <= r_cnt + 1'b1;
                r_phase    <= w_phase_nxt;
                signal_out <= w_sample;
                sym_last   <= (r_cnt == CW'(SPS - 2));
            end else if (r_state == S_RUN) begin
                // Burst ends; every new burst restarts from phase reference 0.
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_acc      <= '0;
                signal_out <= DATA_WIDTH'(IDLE_LEVEL);
                active     <= 1'b0;
                underrun   <= enable;
            end
        end
    end
endmodule

// File: tb/tb_mpsk_modulator.sv
// Bench for mpsk_modulator: four configurations share one stimulus stream
// and are compared every cycle against a symbol-level reference model.
module tb_mpsk_modulator;
    localparam int W   = 16;
    localparam int SPS = 16;
    localparam int NI  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] data = '0;

    always #5 clk = ~clk;

    mpsk_modulator_if #(.BITS_PER_SYMBOL(2)) if0 ();
    mpsk_modulator_if #(.BITS_PER_SYMBOL(2)) if1 ();
    mpsk_modulator_if #(.BITS_PER_SYMBOL(2)) if2 ();
    mpsk_modulator_if #(.BITS_PER_SYMBOL(3)) if3 ();

    assign if0.sym_valid = valid;
    assign if1.sym_valid = valid;
    assign if2.sym_valid = valid;
    assign if3.sym_valid = valid;
    assign if0.sym_data  = data[1:0];
    assign if1.sym_data  = data[1:0];
    assign if2.sym_data  = data[1:0];
    assign if3.sym_data  = data;

    logic [7:0] so  [NI];
    logic       act [NI];
    logic       lst [NI];
    logic       und [NI];
    logic       rdy [NI];

    assign rdy[0] = if0.sym_ready;
    assign rdy[1] = if1.sym_ready;
    assign rdy[2] = if2.sym_ready;
    assign rdy[3] = if3.sym_ready;

    mpsk_modulator #(.BITS_PER_SYMBOL(2)) u_plain (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_sym(if0),
        .signal_out(so[0]), .active(act[0]),
        .sym_last(lst[0]), .underrun(und[0]));

    mpsk_modulator #(.BITS_PER_SYMBOL(2), .DIFF(1)) u_diff (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_sym(if1),
        .signal_out(so[1]), .active(act[1]),
        .sym_last(lst[1]), .underrun(und[1]));

    mpsk_modulator #(.BITS_PER_SYMBOL(2), .GRAY(1)) u_gray (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_sym(if2),
        .signal_out(so[2]), .active(act[2]),
        .sym_last(lst[2]), .underrun(und[2]));

    mpsk_modulator #(.BITS_PER_SYMBOL(3), .GRAY(1)) u_8psk (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_sym(if3),
        .signal_out(so[3]), .active(act[3]),
        .sym_last(lst[3]), .underrun(und[3]));

    int bps [NI] = '{2, 2, 2, 3};
    bit gry [NI] = '{0, 0, 1, 1};
    bit dif [NI] = '{0, 1, 0, 0};

    int tab [W];
    int m_run [NI];
    int m_k   [NI];
    int m_off [NI];
    int m_acc [NI];
    int e_out [NI];
    int e_act [NI];
    int e_lst [NI];
    int e_und [NI];
    bit hs    [NI];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int i,
                         input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d",
                     name, i, $time, got, want);
        end
    endtask

    function automatic int g2b(input int g, input int n);
        int b = 0;
        for (int s = 0; s < n; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_run[i] = 0; m_k[i] = 0; m_off[i] = 0; m_acc[i] = 0;
            e_out[i] = 128; e_act[i] = 0; e_lst[i] = 0; e_und[i] = 0;
            hs[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int m, d, b, p;
        m = 1 << bps[i];
        d = int'(data) % m;
        if (hs[i]) begin
            b = gry[i] ? g2b(d, bps[i]) : d;
            if (dif[i]) begin
                m_acc[i] = (m_acc[i] + b) % m;
                p = m_acc[i];
            end else begin
                p = b;
            end
            m_off[i] = p * (W / m);
            m_k[i] = 0; m_run[i] = 1;
            e_out[i] = tab[m_off[i] % W];
            e_act[i] = 1; e_lst[i] = 0; e_und[i] = 0;
        end else if (m_run[i] != 0 && m_k[i] < SPS - 1) begin
            m_k[i]++;
            e_out[i] = tab[(m_k[i] + m_off[i]) % W];
            e_lst[i] = (m_k[i] == SPS - 1);
            e_und[i] = 0;
        end else if (m_run[i] != 0) begin
            m_run[i] = 0; m_k[i] = 0; m_acc[i] = 0;
            e_out[i] = 128; e_act[i] = 0; e_lst[i] = 0;
            e_und[i] = int'(enable);
        end else begin
            e_und[i] = 0;
        end
    endtask

    // Compare at the falling edge, then advance the model across the
    // next rising edge using the inputs that edge will see.
    task automatic cycle();
        bit r;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            r = enable && (m_run[i] == 0 || m_k[i] == SPS - 1);
            check("sym_ready",  i, int'(rdy[i]), int'(r));
            check("signal_out", i, int'(so[i]),  e_out[i]);
            check("active",     i, int'(act[i]), e_act[i]);
            check("sym_last",   i, int'(lst[i]), e_lst[i]);
            check("underrun",   i, int'(und[i]), e_und[i]);
            hs[i] = valid && r;
            if (rst_n) model_step(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input int s, input int e0, input int e1,
                        input int e2, input int e3);
        int e [NI];
        bit done;
        e = '{e0, e1, e2, e3};
        valid = 1'b1;
        data = 3'(s);
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            cycle();
            done = hs[0];
        end
        if (!done) check("hs_timeout", 0, 0, 1);
        for (int i = 0; i < NI; i++) check("first_sample", i, int'(so[i]), e[i]);
    endtask

    initial begin
        for (int i = 0; i < W; i++)
            tab[i] = 128 + $rtoi($floor(127.0 * $sin(2.0 * 3.14159265358979 * i / W) + 0.5));
        check("model_tab1",  0, tab[1],  177);
        check("model_tab4",  0, tab[4],  255);
        check("model_tab12", 0, tab[12], 1);
        model_reset();

        wait_n(3);
        rst_n = 1'b1;
        wait_n(20);
        check("idle_out", 0, int'(so[0]), 128);

        enable = 1'b1;
        send(0, 128, 128, 128, 128);
        send(1, 255, 255, 255, 218);
        send(2, 128, 1, 1, 218);
        send(3, 1, 128, 128, 255);
        valid = 1'b0;
        wait_n(20);

        send(2, 128, 128, 1, 218);
        valid = 1'b0;
        wait_n(20);

        send(2, 128, 128, 1, 218);
        valid = 1'b0;
        wait_n(5);
        enable = 1'b0;
        wait_n(20);
        enable = 1'b1;

        send(1, 255, 255, 255, 218);
        send(1, 255, 128, 255, 218);
        send(1, 255, 1, 255, 218);
        valid = 1'b0;
        wait_n(20);
        send(1, 255, 255, 255, 218);
        valid = 1'b0;
        wait_n(20);

        send(3, 1, 1, 128, 255);
        send(2, 128, 255, 1, 218);
        valid = 1'b0;
        wait_n(20);

        send(4, 128, 128, 128, 38);
        valid = 1'b0;
        wait_n(20);

        send(3, 1, 1, 128, 255);
        valid = 1'b0;
        wait_n(7);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_out",    i, int'(so[i]),  128);
            check("rst_active", i, int'(act[i]), 0);
        end
        model_reset();
        wait_n(3);
        rst_n = 1'b1;
        send(1, 255, 255, 255, 218);
        valid = 1'b0;
        wait_n(20);

        for (int n = 0; n < 3000; n++) begin
            if (!valid || hs[0]) begin
                valid = ($urandom_range(0, 3) != 0);
                data = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 31) == 0) enable = !enable;
            cycle();
        end
        valid = 1'b0;
        enable = 1'b1;
        wait_n(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mpsk_modulator.md
# mpsk_modulator

Parametrised M-ary PSK carrier modulator for the transmitter path; successor to the single-bit BPSK modulator. It accepts symbols of 1–3 bits through a valid/ready handshake and emits a continuous stream of DAC samples, one per clock. Each symbol produces an integral number of carrier cycles, phase-shifted by symbol × WAVELENGTH/2^BITS_PER_SYMBOL. It adds Gray mapping, differential encoding, burst start/stop and underrun reporting, and sits between the framing logic and the DAC interface.

## Interface
- DATA_WIDTH, 8: DAC sample width.
- WAVELENGTH, 16: samples per carrier cycle, which is also the sine-table depth; must be divisible by 2^BITS_PER_SYMBOL.
- BITS_PER_SYMBOL, 1: 1 = BPSK, 2 = QPSK, 3 = 8PSK.
- CYCLES_PER_SYMBOL, 1: carrier cycles per symbol; SPS = WAVELENGTH × CYCLES_PER_SYMBOL.
- GRAY, 0: 1 = Gray-decode the symbol before phase mapping.
- DIFF, 0: 1 = differential phase encoding.
- IDLE_LEVEL, 2^(DATA_WIDTH-1): output code while silent.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting or continuing a burst.
- sym_valid  in  1  sym_data is valid.
- sym_data  in  BITS_PER_SYMBOL  symbol value.
- sym_ready  out  1  symbol accepted this cycle when high together with sym_valid.
- signal_out  out  DATA_WIDTH  registered sample to the DAC.
- active  out  1  high while a symbol is being output.
- sym_last  out  1  signal_out currently holds the final sample of a symbol.
- underrun  out  1  one-cycle pulse: a burst ended because no symbol was available.

## Operation
- Reset is asynchronous. Reset values: state IDLE, signal_out = IDLE_LEVEL, active = 0, sym_last = 0, underrun = 0, sample counter = 0, differential accumulator = 0. sym_ready is combinational and therefore 0 while enable = 0.
- The block instantiates the existing wave_table_sine (combinational, phase index → sample). The sample is registered into signal_out.
- Symbol mapping, with M = 2^BITS_PER_SYMBOL:
  - b = GRAY ? gray_to_binary(sym_data) : sym_data.
  - If DIFF, acc_new = (acc + b) mod M and p = acc_new; otherwise p = b.
  - offset = p × (WAVELENGTH/M).
- Sample k of a symbol (k = 0..SPS-1) = table[(k + offset) mod WAVELENGTH].
- State IDLE:
  - sym_ready = enable.
  - On handshake: go to RUN, load offset, set k = 0. The accumulator updates only on a handshake.
- State RUN:
  - The counter increments each cycle.
  - sym_ready = enable && (k == SPS-1).
  - At k == SPS-1 with a handshake: the next symbol starts seamlessly with no gap sample.
  - At k == SPS-1 with no handshake and enable = 1: go to IDLE and pulse underrun.
  - At k == SPS-1 with enable = 0: go to IDLE with no underrun.
- enable is examined only at symbol boundaries. Deasserting it mid-symbol does not truncate the current symbol.
- On entering IDLE, the differential accumulator clears to 0, so every burst starts from phase reference 0.
- sym_valid/sym_data are ignored when sym_ready = 0. sym_data must be stable while sym_valid is high.
- The counter is $clog2(SPS) bits wide and wraps at SPS-1 to 0. The phase index is $clog2(WAVELENGTH) bits wide, with modulo addition.

## Timing
- Latency: a handshake in cycle t puts sample 0 of that symbol on signal_out in cycle t+1, and active goes high in t+1.
- The symbol occupies signal_out for cycles t+1..t+SPS. sym_last is high in cycle t+SPS.
- Back-to-back symbols: sym_ready is high in the sym_last cycle, giving one handshake every SPS cycles with no idle samples.
- Stop: in the cycle after the final sym_last, signal_out = IDLE_LEVEL and active = 0. underrun is high in that same cycle, when applicable, for exactly one cycle.
- Reset mid-symbol: outputs take their reset values immediately (asynchronously). Operation resumes in IDLE after rst_n deasserts, and the partially sent symbol is discarded.

## Test plan
Settings for all scenarios unless noted: DATA_WIDTH 8, WAVELENGTH 16, BITS_PER_SYMBOL 2, CYCLES_PER_SYMBOL 1, IDLE_LEVEL 128.

- **Reset/idle:** hold rst_n = 0 and enable = 0, then release. Required: signal_out = 128, active = 0, sym_ready = 0, underrun = 0 for 20 cycles.
- **Back-to-back QPSK:** present symbols 0, 1, 2, 3 with valid continuous and enable = 1. Required: 64 contiguous samples using offsets 0, 4, 8, 12; sym_ready high at the handshake cycle and every 16th cycle after it; sym_last on samples 15, 31, 47, 63; no underrun.
- **Underrun vs clean stop:**
  - Send one symbol (value 2), then drop valid. Required: 16 samples from offset 8, then signal_out = 128 with a single-cycle underrun pulse.
  - Repeat with enable dropped at sample 5. Required: all 16 samples still emitted, no underrun.
- **Differential encoding (DIFF = 1):** send burst 1, 1, 1, stop, then send 1. Required: offsets 4, 8, 12, then 4 after the restart.
- **Gray mapping (GRAY = 1):** send symbols 3 then 2. Required: offsets 8 then 12. With BITS_PER_SYMBOL = 3 and symbol 4: offset 14.
- **Reset mid-symbol:** assert rst_n at sample 7 of a symbol. Required: signal_out = 128 and active = 0 immediately; the first symbol after release starts at sample 0 with a DIFF accumulator of 0.
